// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op encodings, FSM states and width for the HI/LO divide controller.
package hilo_pkg;
    localparam int W = 32;
    typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO} op_e;
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;
endpackage

// File: rtl/hilo_div_ctrl_if.sv
// hilo_div_ctrl_if: ID/EXE operation handshake into the HI/LO divide controller.
interface hilo_div_ctrl_if #(parameter int W = 32);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    modport master (output in_valid, in_op, in_a, in_b, input in_ready);
    modport slave  (input in_valid, in_op, in_a, in_b, output in_ready);
endinterface

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO pair with independent write enables and source muxes.
module hilo_regs #(parameter int W = 32) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic         res_sel,
    input  logic         lo_ones,
    input  logic [W-1:0] src,
    input  logic [W-1:0] div_rem,
    input  logic [W-1:0] div_quot,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
    always_comb begin
        hi_d = hi_we ? (res_sel ? div_rem : src) : hi_q;
        lo_d = lo_we ? (res_sel ? div_quot : lo_ones ? '1 : src) : lo_q;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: EXE-stage controller driving the iterative divider and owning HI/LO.
// HILO_DIV_ZERO_FAST_EN: resolve divide-by-zero locally (hi<=a, lo<=ones) without launching.
module hilo_div_ctrl #(parameter int W = 32) (
    input  logic             clk,
    input  logic             resetn,
    hilo_div_ctrl_if.slave   in_if,
    input  logic             flush,
    output logic             div_go,
    output logic             div_signed,
    output logic [W-1:0]     div_a,
    output logic [W-1:0]     div_b,
    input  logic             div_complete,
    input  logic [W-1:0]     div_rem,
    input  logic [W-1:0]     div_quot,
    output logic [W-1:0]     hi,
    output logic [W-1:0]     lo,
    output logic             busy
);
    import hilo_pkg::*;
    state_e       state_q, state_d;
    logic         div_go_q, div_go_d, div_signed_q, div_signed_d;
    logic [W-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
    logic         accept, is_div, zero, launch, done, hi_we, lo_we;
    always_comb begin
        accept = state_q == IDLE && in_if.in_valid && !flush;
        is_div = in_if.in_op == OP_DIV || in_if.in_op == OP_DIVU;
`ifdef HILO_DIV_ZERO_FAST_EN
        zero = in_if.in_b == '0;
`else
        zero = 1'b0;
`endif
        launch = accept && is_div && !zero;
        // flush beats a coincident completion: the result is discarded
        done = state_q == RUN && div_complete && !flush;
        // GAP keeps div_go low for one cycle so the divider resets its counter
        state_d = state_q == IDLE ? (launch ? RUN : IDLE) :
                  state_q == RUN  ? ((flush || div_complete) ? GAP : RUN) : IDLE;
        div_go_d = state_d == RUN;
        div_signed_d = launch ? in_if.in_op == OP_DIV : div_signed_q;
        div_a_d = launch ? in_if.in_a : div_a_q;
        div_b_d = launch ? in_if.in_b : div_b_q;
        hi_we = done || (accept && (in_if.in_op == OP_MTHI || (is_div && zero)));
        lo_we = done || (accept && (in_if.in_op == OP_MTLO || (is_div && zero)));
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            div_go_q     <= 1'b0;
            div_signed_q <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            div_go_q     <= div_go_d;
            div_signed_q <= div_signed_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
        end
    end
    hilo_regs #(.W(W)) u_regs (
        .clk      (clk),
        .resetn   (resetn),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .res_sel  (done),
        .lo_ones  (zero),
        .src      (in_if.in_a),
        .div_rem  (div_rem),
        .div_quot (div_quot),
        .hi       (hi),
        .lo       (lo)
    );
    assign in_if.in_ready = state_q == IDLE;
    assign busy       = state_q == RUN;
    assign div_go     = div_go_q;
    assign div_signed = div_signed_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: directed scenarios for the HI/LO divide controller; the bench plays the divider.
module tb_hilo_div_ctrl;
    logic        clk = 0, resetn = 0, flush = 0;
    logic        div_go, div_signed, div_complete = 0, busy;
    logic [31:0] div_a, div_b, div_rem = 0, div_quot = 0, hi, lo;
    int vectors = 0, miscompares = 0;

    hilo_div_ctrl_if #(.W(32)) in_if ();

    hilo_div_ctrl #(.W(32)) dut (
        .clk(clk), .resetn(resetn), .in_if(in_if), .flush(flush),
        .div_go(div_go), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
        .div_complete(div_complete), .div_rem(div_rem), .div_quot(div_quot),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        in_if.in_valid = 1; in_if.in_op = op; in_if.in_a = a; in_if.in_b = b;
        tick;
        in_if.in_valid = 0;
    endtask

    // div_go must be high on every cycle until the completion edge, then GAP follows
    task automatic complete(input int lat, input logic [31:0] rem, input logic [31:0] quot);
        for (int i = 1; i <= lat; i++) begin
            vectors++;
            if (div_go !== 1'b1 || busy !== 1'b1 || in_if.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL run_cycle%0d: go=%b busy=%b ready=%b required 1 1 0", i, div_go, busy, in_if.in_ready);
            end
            if (i == lat) begin div_complete = 1; div_rem = rem; div_quot = quot; end
            tick;
        end
        div_complete = 0;
        vectors++;
        if (div_go !== 1'b0 || busy !== 1'b0 || in_if.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL gap: go=%b busy=%b ready=%b required 0 0 0", div_go, busy, in_if.in_ready);
        end
    endtask

    task automatic test_reset;
        resetn = 0; tick; tick;
        vectors++;
        if ({in_if.in_ready, div_go, busy, div_signed} !== 4'b1000 || hi !== 0 || lo !== 0 || div_a !== 0 || div_b !== 0) begin
            miscompares++;
            $display("FAIL reset: ready/go/busy/sgn=%b hi=%h lo=%h a=%h b=%h required 1000 0 0 0 0",
                     {in_if.in_ready, div_go, busy, div_signed}, hi, lo, div_a, div_b);
        end
        resetn = 1; tick;
    endtask

    task automatic test_divu;
        launch(2'd1, 32'd7, 32'd2);
        vectors++;
        if (div_signed !== 1'b0 || div_a !== 32'd7 || div_b !== 32'd2) begin
            miscompares++;
            $display("FAIL divu_req: sgn=%b a=%h b=%h required 0 7 2", div_signed, div_a, div_b);
        end
        complete(5, 32'd1, 32'd3);
        vectors++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            miscompares++;
            $display("FAIL divu_result: hi=%h lo=%h required 1 3", hi, lo);
        end
        tick;
        vectors++;
        if (in_if.in_ready !== 1'b1 || div_go !== 1'b0) begin
            miscompares++;
            $display("FAIL divu_idle: ready=%b go=%b required 1 0", in_if.in_ready, div_go);
        end
    endtask

    task automatic test_div_signed;
        launch(2'd0, 32'hFFFFFFF9, 32'd2);
        vectors++;
        if (div_signed !== 1'b1 || div_a !== 32'hFFFFFFF9) begin
            miscompares++;
            $display("FAIL div_signed: sgn=%b a=%h required 1 fffffff9", div_signed, div_a);
        end
        complete(3, 32'hFFFFFFFF, 32'hFFFFFFFD);
        vectors++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            miscompares++;
            $display("FAIL div_result: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
        end
        tick;
    endtask

    task automatic test_mthi_mtlo;
        in_if.in_valid = 1; in_if.in_op = 2'd2; in_if.in_a = 32'h12345678; in_if.in_b = 32'd0;
        tick;
        vectors++;
        if (hi !== 32'h12345678 || lo !== 32'hFFFFFFFD || in_if.in_ready !== 1'b1 || div_go !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi: hi=%h lo=%h ready=%b go=%b required 12345678 fffffffd 1 0", hi, lo, in_if.in_ready, div_go);
        end
        in_if.in_op = 2'd3; in_if.in_a = 32'h9ABCDEF0;
        tick;
        in_if.in_valid = 0;
        vectors++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || in_if.in_ready !== 1'b1 || div_go !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo: hi=%h lo=%h ready=%b go=%b busy=%b required 12345678 9abcdef0 1 0 0",
                     hi, lo, in_if.in_ready, div_go, busy);
        end
    endtask

    task automatic test_flush;
        launch(2'd1, 32'd100, 32'd3);
        tick; tick;
        flush = 1;
        tick;
        flush = 0;
        vectors++;
        if (div_go !== 1'b0 || busy !== 1'b0 || in_if.in_ready !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            miscompares++;
            $display("FAIL flush_run: go=%b busy=%b ready=%b hi=%h lo=%h required 0 0 0 12345678 9abcdef0",
                     div_go, busy, in_if.in_ready, hi, lo);
        end
        tick;
        vectors++;
        if (in_if.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_idle: ready=%b required 1", in_if.in_ready);
        end
        launch(2'd1, 32'd9, 32'd4);
        complete(2, 32'd1, 32'd2);
        vectors++;
        if (hi !== 32'd1 || lo !== 32'd2) begin
            miscompares++;
            $display("FAIL flush_next: hi=%h lo=%h required 1 2", hi, lo);
        end
        tick;
    endtask

    task automatic test_flush_complete;
        launch(2'd1, 32'd50, 32'd7);
        tick;
        flush = 1; div_complete = 1; div_rem = 32'hAAAA; div_quot = 32'h5555;
        tick;
        flush = 0; div_complete = 0;
        vectors++;
        if (hi !== 32'd1 || lo !== 32'd2 || div_go !== 1'b0 || in_if.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_complete: hi=%h lo=%h go=%b ready=%b required 1 2 0 0", hi, lo, div_go, in_if.in_ready);
        end
        tick;
        vectors++;
        if (in_if.in_ready !== 1'b1 || hi !== 32'd1 || lo !== 32'd2) begin
            miscompares++;
            $display("FAIL flush_complete_idle: ready=%b hi=%h lo=%h required 1 1 2", in_if.in_ready, hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        launch(2'd1, 32'd10, 32'd3);
        in_if.in_valid = 1; in_if.in_a = 32'd20; in_if.in_b = 32'd6;
        complete(3, 32'd1, 32'd3);
        vectors++;
        if (div_a !== 32'd10 || div_b !== 32'd3 || hi !== 32'd1 || lo !== 32'd3) begin
            miscompares++;
            $display("FAIL b2b_first: a=%h b=%h hi=%h lo=%h required a 3 1 3", div_a, div_b, hi, lo);
        end
        tick;
        vectors++;
        if (in_if.in_ready !== 1'b1 || div_go !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_boundary: ready=%b go=%b required 1 0", in_if.in_ready, div_go);
        end
        tick;
        in_if.in_valid = 0;
        vectors++;
        if (div_a !== 32'd20 || div_b !== 32'd6) begin
            miscompares++;
            $display("FAIL b2b_second_req: a=%h b=%h required 14 6", div_a, div_b);
        end
        complete(4, 32'd2, 32'd3);
        vectors++;
        if (hi !== 32'd2 || lo !== 32'd3) begin
            miscompares++;
            $display("FAIL b2b_result: hi=%h lo=%h required 2 3", hi, lo);
        end
        tick;
    endtask

    task automatic test_div_zero;
`ifdef HILO_DIV_ZERO_FAST_EN
        launch(2'd1, 32'd5, 32'd0);
        vectors++;
        if (hi !== 32'd5 || lo !== 32'hFFFFFFFF || div_go !== 1'b0 || busy !== 1'b0 || in_if.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL div_zero_fast: hi=%h lo=%h go=%b busy=%b ready=%b required 5 ffffffff 0 0 1",
                     hi, lo, div_go, busy, in_if.in_ready);
        end
`else
        launch(2'd1, 32'd5, 32'd0);
        vectors++;
        if (div_b !== 32'd0 || div_a !== 32'd5) begin
            miscompares++;
            $display("FAIL div_zero_req: a=%h b=%h required 5 0", div_a, div_b);
        end
        complete(2, 32'd5, 32'hFFFFFFFF);
        vectors++;
        if (hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL div_zero_result: hi=%h lo=%h required 5 ffffffff", hi, lo);
        end
        tick;
`endif
    endtask

    task automatic test_reset_mid_run;
        launch(2'd0, 32'd40, 32'd5);
        tick;
        resetn = 0;
        tick;
        vectors++;
        if (div_go !== 1'b0 || busy !== 1'b0 || in_if.in_ready !== 1'b1 || hi !== 0 || lo !== 0 || div_a !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_run: go=%b busy=%b ready=%b hi=%h lo=%h a=%h required 0 0 1 0 0 0",
                     div_go, busy, in_if.in_ready, hi, lo, div_a);
        end
        resetn = 1;
        tick;
    endtask

    initial begin
        in_if.in_valid = 0; in_if.in_op = 0; in_if.in_a = 0; in_if.in_b = 0;
        test_reset;
        test_divu;
        test_div_signed;
        test_mthi_mtlo;
        test_flush;
        test_flush_complete;
        test_back_to_back;
        test_div_zero;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
